// File: rtl/axil_pkg.sv
// Shared constants and helpers for the AXI4-Lite register file.
// Response codes, a constant clog2 and the byte-offset width helper.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Number of byte-offset address bits for a DATA_W-bit word.
    function automatic int lsb_of(input int data_w);
        return clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/axil_reg_array.sv
// NUM_REGS x DATA_W register storage for the AXI4-Lite slave.
// Ports: clk, rst_n (async clear), byte-strobed write port
// (we/widx/wdata/wstrb), registered read port (re/rok/ridx -> rdata).
module axil_reg_array
    import axil_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [IDX_W-1:0]    widx,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                re,
    input  logic                rok,
    input  logic [IDX_W-1:0]    ridx,
    output logic [DATA_W-1:0]   rdata
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [NUM_REGS];

    // Read samples the old contents on the same edge as a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                mem[r] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we) begin
                for (int b = 0; b < NB; b++) begin
                    if (wstrb[b]) begin
                        mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
                    end
                end
            end
            if (re) begin
                rdata <= rok ? mem[ridx] : '0;
            end
        end
    end

endmodule

// File: rtl/axil_regfile_slave.sv
// AXI4-Lite slave register file with independent AW/W capture,
// B and AR/R channels, decode errors and a write-commit pulse.
module axil_regfile_slave
    import axil_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 8,
    parameter int NUM_REGS = 16,
    localparam int IDX_W   = (NUM_REGS > 1) ? clog2(NUM_REGS) : 1
) (
    input  logic                s_axi_aclk,
    input  logic                s_axi_aresetn,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    output logic [1:0]          s_axi_bresp,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                wr_commit,
    output logic [IDX_W-1:0]    wr_index
);

    localparam int LSB  = lsb_of(DATA_W);
    localparam int AI_W = ADDR_W - LSB;
    localparam int NB   = DATA_W / 8;

    localparam logic [AI_W:0] NREG = (AI_W+1)'(NUM_REGS);

    logic [AI_W-1:0]   aw_idx;
    logic [AI_W-1:0]   ar_idx;
    logic [DATA_W-1:0] w_data;
    logic [NB-1:0]     w_strb;
    logic              aw_full;
    logic              w_full;

    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic ar_hs;
    logic r_hs;
    logic commit;
    logic aw_ok;
    logic ar_ok;
    logic aw_full_nxt;
    logic w_full_nxt;
    logic rvalid_nxt;
    logic unused_ok;

    assign ar_idx = s_axi_araddr[ADDR_W-1:LSB];

    assign aw_ok = {1'b0, aw_idx} < NREG;
    assign ar_ok = {1'b0, ar_idx} < NREG;

    assign aw_hs  = s_axi_awvalid & s_axi_awready;
    assign w_hs   = s_axi_wvalid & s_axi_wready;
    assign b_hs   = s_axi_bvalid & s_axi_bready;
    assign ar_hs  = s_axi_arvalid & s_axi_arready;
    assign r_hs   = s_axi_rvalid & s_axi_rready;
    assign commit = aw_full & w_full & ~s_axi_bvalid;

    // Byte-offset bits never affect decode.
    assign unused_ok = ^{s_axi_awaddr[LSB-1:0],
                         s_axi_araddr[LSB-1:0]};

    // Readies are the registered complement of the next-state
    // occupancy, so the first edge out of reset raises them.
    always_comb begin
        aw_full_nxt = aw_full;
        w_full_nxt  = w_full;
        rvalid_nxt  = s_axi_rvalid;
        if (aw_hs) aw_full_nxt = 1'b1;
        if (w_hs)  w_full_nxt  = 1'b1;
        if (b_hs) begin
            aw_full_nxt = 1'b0;
            w_full_nxt  = 1'b0;
        end
        if (ar_hs) begin
            rvalid_nxt = 1'b1;
        end else if (r_hs) begin
            rvalid_nxt = 1'b0;
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            aw_full       <= 1'b0;
            w_full        <= 1'b0;
            aw_idx        <= '0;
            w_data        <= '0;
            w_strb        <= '0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_arready <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            s_axi_rvalid  <= 1'b0;
            s_axi_rresp   <= RESP_OKAY;
            wr_commit     <= 1'b0;
            wr_index      <= '0;
        end else begin
            aw_full       <= aw_full_nxt;
            w_full        <= w_full_nxt;
            s_axi_awready <= ~aw_full_nxt;
            s_axi_wready  <= ~w_full_nxt;
            s_axi_rvalid  <= rvalid_nxt;
            s_axi_arready <= ~rvalid_nxt;
            wr_commit     <= commit & aw_ok;

            if (aw_hs) begin
                aw_idx <= s_axi_awaddr[ADDR_W-1:LSB];
            end
            if (w_hs) begin
                w_data <= s_axi_wdata;
                w_strb <= s_axi_wstrb;
            end

            if (commit) begin
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= aw_ok ? RESP_OKAY : RESP_DECERR;
            end else if (b_hs) begin
                s_axi_bvalid <= 1'b0;
            end

            if (commit && aw_ok) begin
                wr_index <= aw_idx[IDX_W-1:0];
            end

            if (ar_hs) begin
                s_axi_rresp <= ar_ok ? RESP_OKAY : RESP_DECERR;
            end
        end
    end

    axil_reg_array #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_regs (
        .clk   (s_axi_aclk),
        .rst_n (s_axi_aresetn),
        .we    (commit & aw_ok),
        .widx  (aw_idx[IDX_W-1:0]),
        .wdata (w_data),
        .wstrb (w_strb),
        .re    (ar_hs),
        .rok   (ar_ok),
        .ridx  (ar_idx[IDX_W-1:0]),
        .rdata (s_axi_rdata)
    );

endmodule

// File: doc/axil_regfile_slave.md
Name: axil_regfile_slave

Overview:
- Parametrised AXI4-Lite slave register file. Full write path (AW/W/B) and full read path (AR/R).
- Supports configurable data width, register count, byte strobes and decode-error responses.
- Successor to the write-only 16x32 slave. Adds:
  - independent AW/W acceptance;
  - a read channel;
  - strobe-qualified writes;
  - a commit pulse for downstream logic.
- Sits between an AXI-Lite master (or interconnect) and control/status consumers.

Parameters:
- DATA_W, 32, data bus width in bits; legal values 32 or 64.
- ADDR_W, 8, byte-address width in bits.
- NUM_REGS, 16, number of DATA_W-bit registers; 1..2**(ADDR_W-LSB), where LSB = log2(DATA_W/8).

Ports:
- s_axi_aclk  in  1  clock
- s_axi_aresetn  in  1  reset
- s_axi_awvalid  in  1  write address valid
- s_axi_awready  out  1  write address ready
- s_axi_awaddr  in  ADDR_W  write byte address
- s_axi_wvalid  in  1  write data valid
- s_axi_wready  out  1  write data ready
- s_axi_wdata  in  DATA_W  write data
- s_axi_wstrb  in  DATA_W/8  byte-lane enables
- s_axi_bvalid  out  1  write response valid
- s_axi_bready  in  1  write response ready
- s_axi_bresp  out  2  write response
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address ready
- s_axi_araddr  in  ADDR_W  read byte address
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  read data ready
- s_axi_rdata  out  DATA_W  read data
- s_axi_rresp  out  2  read response
- wr_commit  out  1  one-cycle pulse when a legal write updates a register
- wr_index  out  log2(NUM_REGS) (min 1)  register index of the commit; valid while wr_commit=1

Behaviour:
- Clock and reset:
  - Single clock s_axi_aclk.
  - Reset s_axi_aresetn is asynchronous, active-low.
  - While low: all ready/valid outputs 0, bresp/rresp 0, rdata 0, wr_commit 0, wr_index 0, all registers 0.
  - First rising edge after deassertion sets awready, wready and arready to 1.
- Address decode:
  - index = addr[ADDR_W-1:LSB]; low LSB bits ignored.
  - index >= NUM_REGS is out of range.
- Write address/data capture:
  - AW and W channels are independent. Each has a one-entry holding register (aw_full/w_full) and a registered ready.
  - AW handshake (awvalid & awready): capture awaddr, set aw_full, drop awready next cycle.
  - W handshake: capture wdata and wstrb, set w_full, drop wready next cycle.
  - AW and W may arrive in either order or in the same cycle.
- Write commit:
  - Fires on the first edge where aw_full & w_full & !bvalid.
  - In range: each byte lane with strb=1 updates; lanes with strb=0 are unchanged. bresp=OKAY (00), wr_commit=1 for exactly one cycle, wr_index=index.
  - wstrb=0 in range still returns OKAY and still pulses wr_commit.
  - Out of range: no register changes, bresp=DECERR (11), no wr_commit.
  - bvalid rises on the same edge as the commit.
- Write response:
  - bvalid holds with stable bresp until bready.
  - On the B handshake: clear bvalid, aw_full and w_full; reassert awready and wready on the same edge.
  - Minimum write spacing: AW/W accepted at edge N, commit/bvalid at N+1, with bready=1 handshake at N+2 and next AW/W accepted at N+3.
- Read path:
  - arready=1 when no read is outstanding.
  - AR handshake at edge N: rdata = register[index] registered at N, rvalid=1, arready=0, rresp=OKAY.
  - Out-of-range read: rdata=0, rresp=DECERR.
  - rdata/rresp hold stable until rready.
  - R handshake clears rvalid and sets arready on the same edge. One read per 2 cycles minimum.
- Read/write collision: a read and a commit to the same register on the same edge return the pre-write value.
- Valid stalls: master dropping awvalid/wvalid/arvalid without a handshake has no effect. Nothing is captured without ready.
- Reset mid-transaction: outstanding AW/W/B/R state is discarded immediately. No response is issued for the aborted transfer.

Decomposition:
- Shared package axil_pkg:
  - response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - a clog2 helper function;
  - the LSB-derivation constant function.
- Sub-module axil_reg_array:
  - NUM_REGS x DATA_W storage;
  - byte-strobed synchronous write port and registered read port;
  - asynchronous clear.
- The top level holds the AW/W/B/AR/R handshake logic and the decode.

Test Plan:
- Aligned write: AW and W same cycle, addr=0x08, wdata=0xDEADBEEF, wstrb=0xF, bready=1 -> bvalid one cycle after acceptance, bresp=00, wr_commit pulse with wr_index=2. Then read addr=0x08 -> rdata=0xDEADBEEF, rresp=00.
- Split arrival, W before AW: W (0x11223344) at cycle 0, AW addr=0x04 at cycle 3 -> no bvalid before cycle 4, bvalid at cycle 4, reg1=0x11223344.
- Strobe: reg3=0xAAAAAAAA, then write 0x55555555 with wstrb=0x5 -> read returns 0xAA55AA55.
- Decode error (defaults): write addr=0x40 -> bresp=11, no wr_commit, all regs unchanged. Read addr=0x40 -> rdata=0, rresp=11.
- Backpressure: bready=0 for 5 cycles after bvalid -> bvalid/bresp stable, awready=wready=0 throughout, second AW not accepted. Same check with rready=0 on the read path.
- Async reset: assert reset mid-write while bvalid=1 and rvalid=1 -> outputs go to 0 without a clock edge, regs read 0 after release, readies return to 1 on the first post-reset edge.
